dcache_fill_controller: RTL

//  Sequences the data-cache block datapath in the M stage of the pipelined core.
//  On a load/store miss it stalls the pipeline and, if the victim line is dirty,

---
 rtl/dcache_fill_controller.sv | 90 +++++++++
 1 files changed

// File: rtl/dcache_fill_controller.sv
// dcache_fill_controller: M-stage miss sequencer; dirty-victim write-back then word-by-word refill over AHB.
module dcache_fill_controller #(
  parameter int blocksize = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MemRE,
  input  logic                         MemWE,
  input  logic                         Hit,
  input  logic                         Dirty,
  input  logic                         BusReady,
  output logic                         Stall,
  output logic                         HRequest,
  output logic                         HWrite,
  output logic [1:0]                   AddrSel,
  output logic [$clog2(blocksize)-1:0] Counter,
  output logic                         BlockWE,
  output logic                         CacheWE,
  output logic                         SetValid,
  output logic                         SetDirty,
  output logic                         DirtyVal
);
  localparam int LG = $clog2(blocksize);
  typedef enum logic [1:0] {READY, WRITEBACK, FILL} state_t;
  state_t state, next;
  logic [LG-1:0] count_next;
  logic miss, last;
  assign miss = (MemRE | MemWE) & ~Hit;
  assign last = BusReady && Counter == LG'(blocksize - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= READY;
      Counter <= '0;
    end else begin
      state   <= next;
      Counter <= count_next;
    end
  end
  // Counter wraps to 0 naturally on the last beat because blocksize is a power of 2.
  always_comb begin
    next = state;
    count_next = Counter;
    Stall = 1'b0;
    HRequest = 1'b0;
    HWrite = 1'b0;
    AddrSel = 2'b00;
    BlockWE = 1'b0;
    CacheWE = 1'b0;
    SetValid = 1'b0;
    SetDirty = 1'b0;
    DirtyVal = 1'b0;
    case (state)
      READY: begin
        if (miss) begin
          Stall = 1'b1;
          next = Dirty ? WRITEBACK : FILL;
          count_next = '0;
        end else if (MemWE) begin
          CacheWE = 1'b1;
          SetDirty = 1'b1;
          DirtyVal = 1'b1;
        end
      end
      WRITEBACK: begin
        Stall = 1'b1;
        HRequest = 1'b1;
        HWrite = 1'b1;
        AddrSel = 2'b01;
        count_next = BusReady ? Counter + LG'(1) : Counter;
        next = last ? FILL : WRITEBACK;
      end
      FILL: begin
        Stall = 1'b1;
        HRequest = 1'b1;
        AddrSel = 2'b10;
        BlockWE = 1'b1;
        CacheWE = BusReady;
        count_next = BusReady ? Counter + LG'(1) : Counter;
        SetValid = last;
        SetDirty = last;
        DirtyVal = last & MemWE;
        next = last ? READY : FILL;
      end
      default: begin
        next = READY;
        count_next = '0;
      end
    endcase
  end
endmodule
